// File: rtl/aes_key_expansion.sv
// AES key schedule: expands an Nk-word cipher key into round keys 1..Nr every cycle
// and registers them as one wide bus (round r at [128*r-1 -: 128], w[4r] on top).
module aes_key_expansion #(
  parameter int Nk = 4,
  parameter int Nb = 4,
  parameter int Nr = 10
) (
  input  logic [32*Nk-1:0]    key,
  input  logic                clk,
  output logic [32*Nb*Nr-1:0] full_keys,
  input  logic                rst_n
);

  localparam int NW = Nb * (Nr + 1);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    int idx;
    idx = int'(b);
    return SBOX[2047 - 8*idx -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sub_byte(x[31:24]), sub_byte(x[23:16]), sub_byte(x[15:8]), sub_byte(x[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input int j);
    case (j)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0]          w [NW];
  logic [31:0]          temp;
  logic [32*Nb*Nr-1:0]  full_keys_d;
  logic [32*Nb*Nr-1:0]  full_keys_q;

  // Whole schedule is one combinational cone; only the packed result is registered.
  always_comb begin
    temp        = '0;
    full_keys_d = '0;
    for (int i = 0; i < Nk; i++) begin
      w[i] = key[32*(Nk-i)-1 -: 32];
    end
    for (int i = Nk; i < NW; i++) begin
      temp = w[i-1];
      if (i % Nk == 0) begin
        temp = sub_word(rot_word(temp)) ^ {rcon(i / Nk), 24'h0};
      end else if (Nk == 8 && i % Nk == 4) begin
        temp = sub_word(temp);
      end
      w[i] = w[i-Nk] ^ temp;
    end
    // Round key 0 is the cipher key and is not placed on the bus.
    for (int r = 1; r <= Nr; r++) begin
      for (int j = 0; j < Nb; j++) begin
        full_keys_d[32*Nb*r - 32*j - 1 -: 32] = w[Nb*r + j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_keys_q <= '0;
    end else begin
      full_keys_q <= full_keys_d;
    end
  end

  assign full_keys = full_keys_q;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Bench for aes_key_expansion: Nk=4/6/8 instances driven together, checked against
// known-answer vectors and a byte-level key-schedule model with a derived S-box.
module tb_aes_key_expansion;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [127:0]  key4 = '0;
  logic [191:0]  key6 = '0;
  logic [255:0]  key8 = '0;
  logic [1279:0] fk4;
  logic [1535:0] fk6;
  logic [1791:0] fk8;

  int checks = 0;
  int errors = 0;

  logic [1279:0] exp4_q[$];
  logic [1535:0] exp6_q[$];
  logic [1791:0] exp8_q[$];

  logic [7:0] sb [256];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  aes_key_expansion #(.Nk(4), .Nb(4), .Nr(10)) u_nk4 (
    .key(key4), .clk(clk), .full_keys(fk4), .rst_n(rst_n)
  );
  aes_key_expansion #(.Nk(6), .Nb(4), .Nr(12)) u_nk6 (
    .key(key6), .clk(clk), .full_keys(fk6), .rst_n(rst_n)
  );
  aes_key_expansion #(.Nk(8), .Nb(4), .Nr(14)) u_nk8 (
    .key(key8), .clk(clk), .full_keys(fk8), .rst_n(rst_n)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] xb, inv, r, s;
    for (int x = 0; x < 256; x++) begin
      xb  = x[7:0];
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
      end
      r = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sb[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [1791:0] model(input int nk, input int nr, input logic [255:0] key);
    logic [7:0]    w [60][4];
    logic [7:0]    t [4];
    logic [7:0]    t0;
    logic [7:0]    rc;
    logic [1791:0] fk;
    rc = 8'h01;
    fk = '0;
    for (int i = 0; i < nk; i++)
      for (int b = 0; b < 4; b++)
        w[i][b] = key[32*nk - 1 - 8*(4*i+b) -: 8];
    for (int i = nk; i < 4*(nr+1); i++) begin
      for (int b = 0; b < 4; b++) t[b] = w[i-1][b];
      if (i % nk == 0) begin
        t0 = t[0];
        t[0] = sb[t[1]] ^ rc;
        t[1] = sb[t[2]];
        t[2] = sb[t[3]];
        t[3] = sb[t0];
        rc = xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        for (int b = 0; b < 4; b++) t[b] = sb[t[b]];
      end
      for (int b = 0; b < 4; b++) w[i][b] = w[i-nk][b] ^ t[b];
    end
    for (int r = 1; r <= nr; r++)
      for (int j = 0; j < 4; j++)
        for (int b = 0; b < 4; b++)
          fk[128*r - 1 - 32*j - 8*b -: 8] = w[4*r+j][b];
    return fk;
  endfunction

  // ---------------- checkers ----------------
  task automatic check_bus(input string name, input logic [1791:0] got,
                           input logic [1791:0] exp, input int nr);
    int first;
    checks++;
    if (got !== exp) begin
      errors++;
      first = 1;
      for (int r = nr; r >= 1; r--)
        if (got[128*r-1 -: 128] !== exp[128*r-1 -: 128]) first = r;
      $display("FAIL %s rk%0d got %h required %h", name, first,
               got[128*first-1 -: 128], exp[128*first-1 -: 128]);
    end
  endtask

  task automatic check128(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic push_keys();
    logic [1791:0] m;
    m = model(4, 10, {128'b0, key4});
    exp4_q.push_back(m[1279:0]);
    m = model(6, 12, {64'b0, key6});
    exp6_q.push_back(m[1535:0]);
    m = model(8, 14, key8);
    exp8_q.push_back(m);
  endtask

  task automatic drive(input logic [127:0] k4, input logic [191:0] k6, input logic [255:0] k8);
    @(negedge clk);
    key4 = k4;
    key6 = k6;
    key8 = k8;
    push_keys();
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  // Every rising edge with reset released presents a new bus; pop one entry per instance.
  logic [1279:0] e4;
  logic [1535:0] e6;
  logic [1791:0] e8;

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (exp4_q.size() > 0) begin
        e4 = exp4_q.pop_front();
        check_bus("mon_nk4", {512'b0, fk4}, {512'b0, e4}, 10);
      end
      if (exp6_q.size() > 0) begin
        e6 = exp6_q.pop_front();
        check_bus("mon_nk6", {256'b0, fk6}, {256'b0, e6}, 12);
      end
      if (exp8_q.size() > 0) begin
        e8 = exp8_q.pop_front();
        check_bus("mon_nk8", fk8, e8, 14);
      end
    end
  end

  // ---------------- main sequence ----------------
  logic [255:0] r8;
  logic [255:0] r6;
  logic [255:0] r4;

  initial begin
    build_sbox();
    r8 = rand256();
    r6 = rand256();
    r4 = rand256();
    key4 = r4[127:0];
    key6 = r6[191:0];
    key8 = r8;

    repeat (3) @(posedge clk);
    #2;
    check_bus("reset_nk4", {512'b0, fk4}, '0, 10);
    check_bus("reset_nk6", {256'b0, fk6}, '0, 12);
    check_bus("reset_nk8", fk8, '0, 14);

    drive(128'h2b7e151628aed2a6abf7158809cf4f3c,
          192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
          256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check128("kat4_rk1",  fk4[127:0],     128'ha0fafe1788542cb123a339392a6c7605);
    check128("kat4_rk2",  fk4[255:128],   128'hf2c295f27a96b9435935807a7359f67f);
    check128("kat4_rk10", fk4[1279:1152], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check128("kat6_rk1",  fk6[127:0],     128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    check128("kat6_rk2",  fk6[255:128],   128'hec12068e6c827f6b0e7a95b95c56fec2);
    check128("kat8_rk1",  fk8[127:0],     128'h1f352c073b6108d72d9810a30914dff4);
    check128("kat8_rk2",  fk8[255:128],   128'h9ba354118e6925afa51a8b5f2067fcde);
    check128("kat8_w12",  {96'b0, fk8[383:352]}, {96'b0, 32'ha8b09c1a});

    r6 = rand256();
    r8 = rand256();
    drive(128'h000102030405060708090a0b0c0d0e0f, r6[191:0], r8);
    @(posedge clk);
    #2;
    check128("kat5_rk10", fk4[1279:1152], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Key changes mid-cycle: bus must hold until the next rising edge.
    key4 = '0;
    push_keys();
    #1;
    check128("hold_rk10", fk4[1279:1152], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    @(posedge clk);
    #2;
    check128("zero_rk1",  fk4[127:0],     128'h62636363626363636263636362636363);
    check128("zero_rk10", fk4[1279:1152], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Asynchronous reset between edges clears the held value at once.
    #1;
    key4 = r4[127:0];
    rst_n = 1'b0;
    #1;
    check_bus("async_nk4", {512'b0, fk4}, '0, 10);
    check_bus("async_nk6", {256'b0, fk6}, '0, 12);
    check_bus("async_nk8", fk8, '0, 14);
    @(posedge clk);
    #2;
    check_bus("held_nk4", {512'b0, fk4}, '0, 10);
    check_bus("held_nk6", {256'b0, fk6}, '0, 12);
    check_bus("held_nk8", fk8, '0, 14);

    r4 = rand256();
    r6 = rand256();
    r8 = rand256();
    drive(r4[127:0], r6[191:0], r8);
    rst_n = 1'b1;

    for (int n = 0; n < 40; n++) begin
      r4 = rand256();
      r6 = rand256();
      r8 = rand256();
      if ($urandom_range(0, 3) == 0) r4[127:64] = '0;
      drive(r4[127:0], r6[191:0], r8);
    end

    @(posedge clk);
    #3;
    checks++;
    if (exp4_q.size() + exp6_q.size() + exp8_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending entries required 0",
               exp4_q.size() + exp6_q.size() + exp8_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
